// File: rtl/pdm2pcm_multichannel_pipeline.sv
// Time-multiplexed PDM-to-PCM converter: shared capture, per-channel CIC,
// shift + Q1.15 gain with rounding/saturation, FWFT output FIFO.
// Ports: clk_i/rst_i (async high), enable_i, pdm_i/pdm_valid_i/channel_i,
//   decimation_factor_i/shift_i/gain_i (latched while enable_i=0),
//   pcm_o/pcm_channel_o/pcm_valid_o/pcm_ready_i, clip_o, overflow_o,
//   clear_flags_i, config_error_o.
module pdm2pcm_multichannel_pipeline #(
   parameter int CHANNELS       = 2,
   parameter int CIC_ORDER      = 2,
   parameter int CIC_DELAY      = 1,
   parameter int MAX_DECIMATION = 255,
   parameter int PCM_WIDTH      = 16,
   parameter int FIFO_DEPTH     = 8,
   parameter int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   parameter int ACC_W =
      CIC_ORDER * $clog2(MAX_DECIMATION * CIC_DELAY) + 2
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        enable_i,
   input  logic                        pdm_i,
   input  logic                        pdm_valid_i,
   input  logic [CH_W-1:0]             channel_i,
   input  logic [7:0]                  decimation_factor_i,
   input  logic [4:0]                  shift_i,
   input  logic [15:0]                 gain_i,
   output logic signed [PCM_WIDTH-1:0] pcm_o,
   output logic [CH_W-1:0]             pcm_channel_o,
   output logic                        pcm_valid_o,
   input  logic                        pcm_ready_i,
   output logic [CHANNELS-1:0]         clip_o,
   output logic                        overflow_o,
   input  logic                        clear_flags_i,
   output logic                        config_error_o
);

   localparam int FA_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int PROD_W = ACC_W + 16;
   localparam int RND_W  = PROD_W + 1;
   localparam int ENT_W  = CH_W + PCM_WIDTH;

   localparam logic signed [RND_W-1:0] PCM_MAX =
      RND_W'((2 ** (PCM_WIDTH - 1)) - 1);
   localparam logic signed [RND_W-1:0] PCM_MIN = ~PCM_MAX;
   localparam logic signed [RND_W-1:0] RND_HALF = RND_W'(2 ** 14);

   // ---------------- configuration ----------------
   logic [7:0]  r_q;
   logic [4:0]  shift_q;
   logic [15:0] gain_q;
   logic        cfg_err_q;
   logic        cfg_ok_q;
   logic        r_bad;

   assign r_bad = (decimation_factor_i < 8'd2) ||
                  ({24'd0, decimation_factor_i} > MAX_DECIMATION);

   // cfg_ok_q stays 0 out of reset so nothing runs before a config latch
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_q       <= '0;
         shift_q   <= '0;
         gain_q    <= '0;
         cfg_err_q <= 1'b0;
         cfg_ok_q  <= 1'b0;
      end else if (!enable_i) begin
         r_q       <= decimation_factor_i;
         shift_q   <= shift_i;
         gain_q    <= gain_i;
         cfg_err_q <= r_bad;
         cfg_ok_q  <= !r_bad;
      end
   end

   // ---------------- input / integrators ----------------
   logic             ch_ok;
   logic [CH_W-1:0]  ch_sel;
   logic             accept;
   logic             dec_evt;
   logic [7:0]       cnt_q   [CHANNELS];
   logic [ACC_W-1:0] integ_q [CHANNELS][CIC_ORDER];
   logic [ACC_W-1:0] integ_d [CIC_ORDER];

   assign ch_ok   = 32'(channel_i) < CHANNELS;
   assign ch_sel  = ch_ok ? channel_i : '0;
   assign accept  = enable_i & cfg_ok_q & pdm_valid_i & ch_ok;
   assign dec_evt = accept & (cnt_q[ch_sel] == r_q - 8'd1);

   // Cascade uses each stage's updated value in the same cycle;
   // wrap-around is harmless because the combs cancel it.
   always_comb begin : integ_chain
      logic [ACC_W-1:0] a;
      a = pdm_i ? ACC_W'(1) : '1;
      for (int k = 0; k < CIC_ORDER; k++) begin
         a = integ_q[ch_sel][k] + a;
         integ_d[k] = a;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int c = 0; c < CHANNELS; c++) begin
            cnt_q[c] <= '0;
            for (int k = 0; k < CIC_ORDER; k++) integ_q[c][k] <= '0;
         end
      end else if (!enable_i) begin
         for (int c = 0; c < CHANNELS; c++) begin
            cnt_q[c] <= '0;
            for (int k = 0; k < CIC_ORDER; k++) integ_q[c][k] <= '0;
         end
      end else if (accept) begin
         cnt_q[ch_sel] <= dec_evt ? 8'd0 : cnt_q[ch_sel] + 8'd1;
         for (int k = 0; k < CIC_ORDER; k++) integ_q[ch_sel][k] <= integ_d[k];
      end
   end

   // ---------------- capture (T) ----------------
   logic             cap_v_q;
   logic [CH_W-1:0]  cap_ch_q;
   logic [ACC_W-1:0] cap_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cap_v_q  <= 1'b0;
         cap_ch_q <= '0;
         cap_q    <= '0;
      end else if (!enable_i) begin
         cap_v_q <= 1'b0;
      end else begin
         cap_v_q <= dec_evt;
         if (dec_evt) begin
            cap_q    <= integ_d[CIC_ORDER-1];
            cap_ch_q <= ch_sel;
         end
      end
   end

   // ---------------- combs (T+1) ----------------
   logic [ACC_W-1:0] dl_q [CHANNELS][CIC_ORDER][CIC_DELAY];
   logic [ACC_W-1:0] comb_tap [CIC_ORDER];
   logic [ACC_W-1:0] comb_res;
   logic             cmb_v_q;
   logic [CH_W-1:0]  cmb_ch_q;
   logic [ACC_W-1:0] cmb_q;

   always_comb begin : comb_chain
      logic [ACC_W-1:0] c;
      c = cap_q;
      for (int k = 0; k < CIC_ORDER; k++) begin
         comb_tap[k] = c;
         c = c - dl_q[cap_ch_q][k][CIC_DELAY-1];
      end
      comb_res = c;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k < CIC_ORDER; k++)
               for (int m = 0; m < CIC_DELAY; m++) dl_q[c][k][m] <= '0;
      end else if (!enable_i) begin
         for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k < CIC_ORDER; k++)
               for (int m = 0; m < CIC_DELAY; m++) dl_q[c][k][m] <= '0;
      end else if (cap_v_q) begin
         for (int k = 0; k < CIC_ORDER; k++) begin
            dl_q[cap_ch_q][k][0] <= comb_tap[k];
            for (int m = 1; m < CIC_DELAY; m++)
               dl_q[cap_ch_q][k][m] <= dl_q[cap_ch_q][k][m-1];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cmb_v_q  <= 1'b0;
         cmb_ch_q <= '0;
         cmb_q    <= '0;
      end else if (!enable_i) begin
         cmb_v_q <= 1'b0;
      end else begin
         cmb_v_q  <= cap_v_q;
         cmb_ch_q <= cap_ch_q;
         cmb_q    <= comb_res;
      end
   end

   // ---------------- shift + gain (T+2) ----------------
   logic signed [ACC_W-1:0]  y;
   logic signed [PROD_W-1:0] prod;
   logic                     mul_v_q;
   logic [CH_W-1:0]          mul_ch_q;
   logic signed [PROD_W-1:0] mul_q;

   assign y    = $signed(cmb_q) >>> shift_q;
   assign prod = PROD_W'(y) * PROD_W'($signed(gain_q));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mul_v_q  <= 1'b0;
         mul_ch_q <= '0;
         mul_q    <= '0;
      end else if (!enable_i) begin
         mul_v_q <= 1'b0;
      end else begin
         mul_v_q  <= cmb_v_q;
         mul_ch_q <= cmb_ch_q;
         mul_q    <= prod;
      end
   end

   // ---------------- round + saturate + push (T+3) ----------------
   logic signed [RND_W-1:0] rnd_sum;
   logic signed [RND_W-1:0] rnd;
   logic                    sat_hi;
   logic                    sat_lo;
   logic [PCM_WIDTH-1:0]    pcm_d;

   assign rnd_sum = RND_W'(mul_q) + RND_HALF;
   assign rnd     = rnd_sum >>> 15;
   assign sat_hi  = rnd > PCM_MAX;
   assign sat_lo  = rnd < PCM_MIN;
   assign pcm_d   = sat_hi ? PCM_MAX[PCM_WIDTH-1:0] :
                    sat_lo ? PCM_MIN[PCM_WIDTH-1:0] :
                             rnd[PCM_WIDTH-1:0];

   // ---------------- output FIFO ----------------
   logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
   logic [FA_W:0]    wp_q;
   logic [FA_W:0]    rp_q;
   logic             empty;
   logic             full;
   logic             push;
   logic             pop;
   logic             push_ok;

   assign empty   = (wp_q == rp_q);
   assign full    = (wp_q[FA_W] != rp_q[FA_W]) &&
                    (wp_q[FA_W-1:0] == rp_q[FA_W-1:0]);
   assign push    = mul_v_q;
   assign pop     = !empty && pcm_ready_i;
   assign push_ok = push && (!full || pop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         if (pop)     rp_q <= rp_q + (FA_W+1)'(1);
         if (push_ok) wp_q <= wp_q + (FA_W+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wp_q[FA_W-1:0]] <= {mul_ch_q, pcm_d};
   end

   // ---------------- sticky flags ----------------
   logic [CHANNELS-1:0] clip_q;
   logic                overflow_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         clip_q     <= '0;
         overflow_q <= 1'b0;
      end else if (clear_flags_i) begin
         clip_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push && (sat_hi || sat_lo)) clip_q[mul_ch_q] <= 1'b1;
         if (push && full && !pop)       overflow_q <= 1'b1;
      end
   end

   assign {pcm_channel_o, pcm_o} = empty ? '0 : mem_q[rp_q[FA_W-1:0]];
   assign pcm_valid_o    = !empty;
   assign clip_o         = clip_q;
   assign overflow_o     = overflow_q;
   assign config_error_o = cfg_err_q;

endmodule

// File: tb/tb_pdm2pcm_multichannel_pipeline.sv
// Directed bench for pdm2pcm_multichannel_pipeline (CHANNELS=2, ORDER=2, M=1).
// Expected PCM values are hand-derived CIC/gain results.
module tb_pdm2pcm_multichannel_pipeline;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic               enable_i;
   logic               pdm_i;
   logic               pdm_valid_i;
   logic [0:0]         channel_i;
   logic [7:0]         decimation_factor_i;
   logic [4:0]         shift_i;
   logic [15:0]        gain_i;
   logic signed [15:0] pcm_o;
   logic [0:0]         pcm_channel_o;
   logic               pcm_valid_o;
   logic               pcm_ready_i;
   logic [1:0]         clip_o;
   logic               overflow_o;
   logic               clear_flags_i;
   logic               config_error_o;

   int n_assert = 0;
   int n_fail   = 0;

   int il_c [6] = '{0, 1, 0, 1, 0, 1};
   int il_v [6] = '{5, -5, 8, -8, 8, -8};
   int ov_c [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
   int ov_v [8] = '{3, -3, 4, -4, 4, -4, 4, -4};
   int pp_c [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
   int pp_v [8] = '{-3, 4, -4, 4, -4, 4, -4, 4};

   pdm2pcm_multichannel_pipeline dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .enable_i            (enable_i),
      .pdm_i               (pdm_i),
      .pdm_valid_i         (pdm_valid_i),
      .channel_i           (channel_i),
      .decimation_factor_i (decimation_factor_i),
      .shift_i             (shift_i),
      .gain_i              (gain_i),
      .pcm_o               (pcm_o),
      .pcm_channel_o       (pcm_channel_o),
      .pcm_valid_o         (pcm_valid_o),
      .pcm_ready_i         (pcm_ready_i),
      .clip_o              (clip_o),
      .overflow_o          (overflow_o),
      .clear_flags_i       (clear_flags_i),
      .config_error_o      (config_error_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cfg(input int r, input int sh, input int g);
      enable_i            = 1'b0;
      decimation_factor_i = 8'(r);
      shift_i             = 5'(sh);
      gain_i              = 16'(g);
      tick();
      enable_i = 1'b1;
   endtask

   task automatic feed(input int ch, input int b);
      pdm_valid_i = 1'b1;
      channel_i   = 1'(ch);
      pdm_i       = 1'(b);
      tick();
      pdm_valid_i = 1'b0;
   endtask

   task automatic flush();
      repeat (3) tick();
   endtask

   task automatic popchk(input string tag, input int ch, input int v);
      chk({tag, "_valid"}, int'(pcm_valid_o), 1);
      chk({tag, "_pcm"}, int'(pcm_o), v);
      chk({tag, "_ch"}, int'(pcm_channel_o), ch);
      pcm_ready_i = 1'b1;
      tick();
      pcm_ready_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1;
      enable_i = 1'b0;
      pdm_i = 1'b0;
      pdm_valid_i = 1'b0;
      channel_i = '0;
      decimation_factor_i = 8'd4;
      shift_i = '0;
      gain_i = '0;
      pcm_ready_i = 1'b0;
      clear_flags_i = 1'b0;
      tick();
      tick();
      rst_i = 1'b0;
      chk("rst_valid", int'(pcm_valid_o), 0);
      chk("rst_pcm", int'(pcm_o), 0);
      chk("rst_ch", int'(pcm_channel_o), 0);
      chk("rst_clip", int'(clip_o), 0);
      chk("rst_ovf", int'(overflow_o), 0);
      chk("rst_cfgerr", int'(config_error_o), 0);

      // ones on ch0, R=4, gain ~+1: 10,16,16 and latency
      cfg(4, 0, 16'h7FFF);
      repeat (4) feed(0, 1);
      tick();
      tick();
      chk("lat_early", int'(pcm_valid_o), 0);
      tick();
      chk("lat_on", int'(pcm_valid_o), 1);
      chk("lat_pcm", int'(pcm_o), 10);
      repeat (8) feed(0, 1);
      flush();
      chk("hold_pcm", int'(pcm_o), 10);
      popchk("imp0", 0, 10);
      popchk("imp1", 0, 16);
      popchk("imp2", 0, 16);
      chk("imp_empty", int'(pcm_valid_o), 0);

      // gain -1 with shift 1: y=5, p=-163840 -> -5
      cfg(4, 1, 16'h8000);
      repeat (4) feed(0, 1);
      flush();
      popchk("neg", 0, -5);

      // interleaved channels, gain 0.5
      cfg(4, 0, 16'h4000);
      for (int i = 0; i < 24; i++) feed(i % 2, (i % 2 == 0) ? 1 : 0);
      flush();
      for (int i = 0; i < 6; i++)
         popchk($sformatf("il%0d", i), il_c[i], il_v[i]);
      chk("il_empty", int'(pcm_valid_o), 0);

      // overflow: 10 samples into 8 entries
      cfg(2, 0, 16'h7FFF);
      for (int i = 0; i < 20; i++) feed(i % 2, (i % 2 == 0) ? 1 : 0);
      flush();
      chk("ovf_set", int'(overflow_o), 1);
      for (int i = 0; i < 8; i++)
         popchk($sformatf("ov%0d", i), ov_c[i], ov_v[i]);
      chk("ovf_empty", int'(pcm_valid_o), 0);
      clear_flags_i = 1'b1;
      tick();
      clear_flags_i = 1'b0;
      chk("ovf_clr", int'(overflow_o), 0);

      // push and pop in the same cycle while full
      cfg(2, 0, 16'h7FFF);
      for (int i = 0; i < 16; i++) feed(i % 2, (i % 2 == 0) ? 1 : 0);
      flush();
      chk("pp_full_noovf", int'(overflow_o), 0);
      feed(0, 1);
      feed(0, 1);
      tick();
      tick();
      pcm_ready_i = 1'b1;
      tick();
      pcm_ready_i = 1'b0;
      chk("pp_noovf", int'(overflow_o), 0);
      for (int i = 0; i < 8; i++)
         popchk($sformatf("pp%0d", i), pp_c[i], pp_v[i]);
      chk("pp_empty", int'(pcm_valid_o), 0);

      // saturation, R=255
      cfg(255, 0, 16'h7FFF);
      repeat (510) feed(0, 1);
      flush();
      popchk("satp0", 0, 32639);
      popchk("satp1", 0, 32767);
      chk("satp_clip", int'(clip_o), 1);
      cfg(255, 0, 16'h7FFF);
      repeat (510) feed(0, 0);
      flush();
      popchk("satn0", 0, -32639);
      popchk("satn1", 0, -32768);
      chk("satn_clip", int'(clip_o), 1);
      clear_flags_i = 1'b1;
      tick();
      clear_flags_i = 1'b0;
      chk("clip_clr", int'(clip_o), 0);

      // illegal R, then R change while enabled
      cfg(1, 0, 16'h7FFF);
      chk("cfg_err_set", int'(config_error_o), 1);
      repeat (8) feed(0, 1);
      flush();
      chk("cfg_err_noout", int'(pcm_valid_o), 0);
      decimation_factor_i = 8'd4;
      tick();
      chk("cfg_err_hold", int'(config_error_o), 1);
      repeat (8) feed(0, 1);
      flush();
      chk("cfg_err_noout2", int'(pcm_valid_o), 0);
      cfg(4, 0, 16'h7FFF);
      chk("cfg_err_clr", int'(config_error_o), 0);
      decimation_factor_i = 8'd2;
      repeat (4) feed(0, 1);
      flush();
      popchk("cfg_frozen", 0, 10);
      chk("cfg_frozen_one", int'(pcm_valid_o), 0);

      // async reset mid-stream with a full FIFO and overflow set
      cfg(2, 0, 16'h7FFF);
      for (int i = 0; i < 20; i++) feed(i % 2, (i % 2 == 0) ? 1 : 0);
      feed(0, 1);
      feed(1, 0);
      chk("prerst_ovf", int'(overflow_o), 1);
      rst_i = 1'b1;
      #1;
      chk("mrst_valid", int'(pcm_valid_o), 0);
      chk("mrst_pcm", int'(pcm_o), 0);
      chk("mrst_ovf", int'(overflow_o), 0);
      tick();
      rst_i = 1'b0;
      cfg(4, 0, 16'h7FFF);
      repeat (3) feed(0, 1);
      flush();
      chk("mrst_partial", int'(pcm_valid_o), 0);
      feed(0, 1);
      flush();
      popchk("mrst_first", 0, 10);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
